// File: rtl/femto_pkg.sv
// femto_pkg: shared types and constants for the femtoRV32 multi-cycle controller.
// The TRAP state is always part of the enum; it is only reachable when
// FEMTO_ILLEGAL_TRAP_EN is defined.
package femto_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_IALU    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_UNKNOWN = 3'd5
    } instr_class_e;

    // IR[6:2] major opcodes
    localparam logic [4:0] OPC_R      = 5'b01100;
    localparam logic [4:0] OPC_IALU   = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// opcode_class: combinational IR[6:2] -> instruction class decode.
module opcode_class
    import femto_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [2:0] instr_cls
);

    // Anything outside the five supported major opcodes is UNKNOWN
    always_comb begin
        instr_cls = CLS_UNKNOWN;
        case (opcode)
            OPC_R:      instr_cls = CLS_R;
            OPC_IALU:   instr_cls = CLS_IALU;
            OPC_LOAD:   instr_cls = CLS_LOAD;
            OPC_STORE:  instr_cls = CLS_STORE;
            OPC_BRANCH: instr_cls = CLS_BRANCH;
            default:    instr_cls = CLS_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer for femtoRV32 with a
// single shared memory port. Outputs are decoded from the registered state and
// opcode class; only the FETCH enables (mem_ready) and the EXEC branch PC write
// (branch_taken) are Mealy.
// Optional feature: define FEMTO_ILLEGAL_TRAP_EN to add the TRAP state and the
// illegal_instr output; otherwise unknown opcodes retire as NOPs.
module multicycle_ctrl
    import femto_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg
`ifdef FEMTO_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);

    state_e     state, state_nxt;
    logic [2:0] cls;

    opcode_class u_opcode_class (
        .opcode    (opcode),
        .instr_cls (cls)
    );

    // State register; reset drops straight to IDLE, abandoning any access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and control decode; every output defaults to 0
    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_src      = 1'b0;
        alu_op       = ALUOP_ADD;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
`ifdef FEMTO_ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                // IR and PC+4 load on the completing edge
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls == CLS_UNKNOWN) begin
`ifdef FEMTO_ILLEGAL_TRAP_EN
                    state_nxt = S_TRAP;
`else
                    state_nxt = S_FETCH;
`endif
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    CLS_R: begin
                        alu_op    = ALUOP_FUNCT;
                        state_nxt = S_WB;
                    end
                    CLS_IALU: begin
                        alu_src   = 1'b1;
                        alu_op    = ALUOP_FUNCT;
                        state_nxt = S_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src   = 1'b1;
                        alu_op    = ALUOP_ADD;
                        state_nxt = S_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op    = ALUOP_SUB;
                        pc_write  = branch_taken;
                        pc_src    = branch_taken;
                        state_nxt = S_FETCH;
                    end
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                // ALU controls held so the effective address stays stable
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == CLS_STORE);
                alu_src      = 1'b1;
                alu_op       = ALUOP_ADD;
                if (mem_ready)
                    state_nxt = (cls == CLS_LOAD) ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == CLS_LOAD);
                state_nxt  = S_FETCH;
            end
`ifdef FEMTO_ILLEGAL_TRAP_EN
            S_TRAP: illegal_instr = 1'b1;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle vectors for multicycle_ctrl.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] opcode = 5'b0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic       alu_src, reg_write, mem_to_reg;
    logic [1:0] alu_op;
`ifdef FEMTO_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    int passed = 0;
    int total  = 0;

    // {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src, alu_op, reg_write, mem_to_reg}
    wire [10:0] outs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                        alu_src, alu_op, reg_write, mem_to_reg};

    localparam logic [10:0] O_ZERO  = 11'b000_0000_0000;
    localparam logic [10:0] O_FWAIT = 11'b100_0000_0000;
    localparam logic [10:0] O_FDONE = 11'b100_1100_0000;
    localparam logic [10:0] O_EX_R  = 11'b000_0000_1000;
    localparam logic [10:0] O_EX_I  = 11'b000_0001_1000;
    localparam logic [10:0] O_EX_LS = 11'b000_0001_0000;
    localparam logic [10:0] O_EX_BT = 11'b000_0110_0100;
    localparam logic [10:0] O_EX_BN = 11'b000_0000_0100;
    localparam logic [10:0] O_MEM_L = 11'b101_0001_0000;
    localparam logic [10:0] O_MEM_S = 11'b111_0001_0000;
    localparam logic [10:0] O_WB    = 11'b000_0000_0010;
    localparam logic [10:0] O_WB_L  = 11'b000_0000_0011;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg)
`ifdef FEMTO_ILLEGAL_TRAP_EN
        ,
        .illegal_instr(illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    // Hold reset for two edges, release on a falling edge: the current cycle is then IDLE
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (outs !== O_ZERO) $display("FAIL reset_outs got=%b exp=%b", outs, O_ZERO);
        else passed++;
`ifdef FEMTO_ILLEGAL_TRAP_EN
        total++;
        if (illegal_instr !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", illegal_instr);
        else passed++;
`endif
    endtask

    // R-type, zero waits: next FETCH request at cycle 5
    task automatic test_rtype();
        logic [12:0] t [6];
        t = '{{2'b10, O_ZERO}, {2'b10, O_FDONE}, {2'b10, O_ZERO},
              {2'b10, O_EX_R}, {2'b10, O_WB}, {2'b10, O_FDONE}};
        opcode = 5'b01100;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = t[i][12]; branch_taken = t[i][11]; #1;
            total++;
            if (outs !== t[i][10:0]) $display("FAIL rtype cyc%0d got=%b exp=%b", i, outs, t[i][10:0]);
            else passed++;
        end
    endtask

    task automatic test_ialu();
        logic [12:0] t [6];
        t = '{{2'b00, O_ZERO}, {2'b10, O_FDONE}, {2'b00, O_ZERO},
              {2'b10, O_EX_I}, {2'b10, O_WB}, {2'b00, O_FWAIT}};
        opcode = 5'b00100;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = t[i][12]; branch_taken = t[i][11]; #1;
            total++;
            if (outs !== t[i][10:0]) $display("FAIL ialu cyc%0d got=%b exp=%b", i, outs, t[i][10:0]);
            else passed++;
        end
    endtask

    // LOAD: 2 FETCH waits, 1 MEM wait, stray mem_ready in DECODE ignored; 8 cycles
    task automatic test_load_waits();
        logic [12:0] t [10];
        t = '{{2'b00, O_ZERO}, {2'b00, O_FWAIT}, {2'b00, O_FWAIT}, {2'b10, O_FDONE},
              {2'b10, O_ZERO}, {2'b00, O_EX_LS}, {2'b00, O_MEM_L}, {2'b10, O_MEM_L},
              {2'b00, O_WB_L}, {2'b00, O_FWAIT}};
        opcode = 5'b00000;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = t[i][12]; branch_taken = t[i][11]; #1;
            total++;
            if (outs !== t[i][10:0]) $display("FAIL load cyc%0d got=%b exp=%b", i, outs, t[i][10:0]);
            else passed++;
        end
    endtask

    // STORE: mem_we only in MEM, no reg_write anywhere, straight back to FETCH
    task automatic test_store();
        logic [12:0] t [6];
        t = '{{2'b10, O_ZERO}, {2'b10, O_FDONE}, {2'b10, O_ZERO},
              {2'b10, O_EX_LS}, {2'b10, O_MEM_S}, {2'b00, O_FWAIT}};
        opcode = 5'b01000;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = t[i][12]; branch_taken = t[i][11]; #1;
            total++;
            if (outs !== t[i][10:0]) $display("FAIL store cyc%0d got=%b exp=%b", i, outs, t[i][10:0]);
            else passed++;
        end
    endtask

    // Taken branch then not-taken branch back to back; branch_taken in DECODE ignored
    task automatic test_back_to_back_branch();
        logic [12:0] t [8];
        t = '{{2'b10, O_ZERO}, {2'b10, O_FDONE}, {2'b11, O_ZERO}, {2'b01, O_EX_BT},
              {2'b10, O_FDONE}, {2'b11, O_ZERO}, {2'b10, O_EX_BN}, {2'b00, O_FWAIT}};
        opcode = 5'b11000;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = t[i][12]; branch_taken = t[i][11]; #1;
            total++;
            if (outs !== t[i][10:0]) $display("FAIL branch cyc%0d got=%b exp=%b", i, outs, t[i][10:0]);
            else passed++;
        end
    endtask

    task automatic test_unknown();
        opcode = 5'b11111;
        apply_reset();
        mem_ready = 1'b1; #1;
        @(negedge clk); #1;
        total++;
        if (outs !== O_FDONE) $display("FAIL unk_fetch got=%b exp=%b", outs, O_FDONE);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (outs !== O_ZERO) $display("FAIL unk_decode got=%b exp=%b", outs, O_ZERO);
        else passed++;
`ifdef FEMTO_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            total++;
            if (outs !== O_ZERO || illegal_instr !== 1'b1)
                $display("FAIL trap cyc%0d got=%b/%b exp=%b/1", i, outs, illegal_instr, O_ZERO);
            else passed++;
        end
        rst_n = 1'b0; #1;
        total++;
        if (illegal_instr !== 1'b0) $display("FAIL trap_clear got=%b exp=0", illegal_instr);
        else passed++;
`else
        // NOP: straight back to FETCH with no enables in between
        @(negedge clk);
        mem_ready = 1'b0; #1;
        total++;
        if (outs !== O_FWAIT) $display("FAIL unk_refetch got=%b exp=%b", outs, O_FWAIT);
        else passed++;
`endif
    endtask

    // Reset while a store waits in MEM: outputs drop before any clock edge
    task automatic test_reset_mid_store();
        opcode = 5'b01000;
        apply_reset();
        mem_ready = 1'b1;
        @(negedge clk); // FETCH
        @(negedge clk); // DECODE
        @(negedge clk); // EXEC
        @(negedge clk); // MEM
        mem_ready = 1'b0; #1;
        total++;
        if (outs !== O_MEM_S) $display("FAIL mid_mem got=%b exp=%b", outs, O_MEM_S);
        else passed++;
        #1 rst_n = 1'b0; #1;
        total++;
        if (outs !== O_ZERO) $display("FAIL async_rst got=%b exp=%b", outs, O_ZERO);
        else passed++;
        @(negedge clk);
        mem_ready = 1'b1;
        rst_n = 1'b1; #1;
        total++;
        if (outs !== O_ZERO) $display("FAIL rst_idle got=%b exp=%b", outs, O_ZERO);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (outs !== O_FDONE) $display("FAIL rst_refetch got=%b exp=%b", outs, O_FDONE);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_ialu();
        test_load_waits();
        test_store();
        test_back_to_back_branch();
        test_unknown();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the femtoRV32 core with one shared memory port. It steps the datapath through IDLE, FETCH, DECODE, EXEC, MEM and WB. It arbitrates the single memory port between instruction fetch and data access, and drives the ALU, register-file, PC and IR enables each cycle. It sits beside the datapath: it consumes the IR opcode field, the branch-compare result and the memory handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  5  IR[6:2]; valid from DECODE onward
- branch_taken  in  1  datapath comparator result for the current branch; sampled in EXEC
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load PC
- pc_src  out  1  PC source: 0 = PC+4, 1 = branch target (old_pc + imm)
- alu_src  out  1  ALU operand B source: 0 = rs2, 1 = immediate
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  write-back source: 0 = ALU, 1 = memory data
- illegal_instr  out  1  unknown opcode trap; present only with the macro, see Configuration

## Operation
- Instruction classes by opcode:
  - R = 01100
  - I-ALU = 00100
  - LOAD = 00000
  - STORE = 01000
  - BRANCH = 11000
  - Every other value is UNKNOWN.
- IDLE: entered on reset. All outputs are 0. Moves to FETCH on the next clock.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0.
  - Stays in FETCH while mem_ready = 0.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 with pc_src = 0, then go to DECODE. The datapath captures old_pc on the same edge.
- DECODE: register-file read, one cycle. Next state:
  - R, I-ALU, LOAD, STORE, BRANCH → EXEC.
  - UNKNOWN → FETCH, or TRAP when the macro is set.
- EXEC:
  - R: alu_src = 0, alu_op = 10, then WB.
  - I-ALU: alu_src = 1, alu_op = 10, then WB.
  - LOAD / STORE: alu_src = 1, alu_op = 00, then MEM.
  - BRANCH: alu_src = 0, alu_op = 01. If branch_taken = 1, assert pc_write with pc_src = 1 in this cycle. Then go to FETCH.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = 1 for STORE only.
  - alu_src = 1 and alu_op = 00 are held so the address stays stable.
  - Stays in MEM while mem_ready = 0.
  - On mem_ready: LOAD → WB, STORE → FETCH.
- WB: reg_write = 1. mem_to_reg = 1 for LOAD, otherwise 0. Then go to FETCH.
- Any output not named for a state is 0 in that state.

## Timing
- Outputs are decoded from the registered state and the opcode.
- Mealy exceptions, all in the same cycle as the condition:
  - ir_write and pc_write in FETCH, gated by mem_ready.
  - pc_write in EXEC, gated by branch_taken.
- Cycles per instruction with zero wait states:
  - BRANCH = 3
  - R, I-ALU, STORE = 4
  - LOAD = 5
  - Each memory wait cycle adds one cycle.
- Handshake rules:
  - mem_req, mem_we and mem_addr_sel stay constant from the first cycle of a FETCH or MEM visit until the cycle mem_ready is sampled high.
  - mem_req drops the cycle after completion.
  - A mem_ready seen outside FETCH or MEM is ignored.
- Reset:
  - rst_n low forces IDLE asynchronously and all outputs to 0 immediately, including mid-access. An abandoned memory request is never completed.
  - After rst_n rises, the first mem_req appears one clock after IDLE.
- Back-to-back instructions: the FETCH request is asserted in the cycle right after WB, MEM (store) or EXEC (branch). There is no bubble.

## Configuration
- FEMTO_ILLEGAL_TRAP_EN
  - Defined: an UNKNOWN opcode in DECODE goes to TRAP. TRAP holds illegal_instr = 1 with all other outputs 0, and is left only by reset.
  - Undefined: the TRAP state and the illegal_instr port do not exist. An UNKNOWN opcode executes as a NOP (DECODE → FETCH) with no register or memory side effects.

## Structure
- Shared package femto_pkg holds:
  - the state enum, including TRAP;
  - the opcode constants (OPC_R, OPC_IALU, OPC_LOAD, OPC_STORE, OPC_BRANCH);
  - the ALU-op constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - the instruction-class enum.
- One sub-module, opcode_class: combinational opcode → class decode, reused by the FSM next-state and output logic.

## Test plan
- Reset, then R-type 01100 with mem_ready tied high → IDLE, FETCH, DECODE, EXEC (alu_op = 10), WB (reg_write = 1). The next FETCH mem_req is high at cycle 5 after reset release.
- LOAD 00000 with 2 wait cycles in FETCH and 1 in MEM → mem_addr_sel is 0 then 1, and mem_req is held throughout each wait. WB has mem_to_reg = 1. Total 8 cycles.
- STORE 01000 → MEM has mem_we = 1 and alu_src = 1. reg_write is never asserted. Returns to FETCH after the mem_ready cycle.
- BRANCH 11000, once with branch_taken = 1 and once with 0 → EXEC shows pc_write = 1 with pc_src = 1 only when taken. Each takes 3 cycles.
- Opcode 11111: with the macro, TRAP and illegal_instr = 1 held for 10 cycles, cleared only by rst_n. Without the macro, DECODE → FETCH and no enables are asserted.
- Drive rst_n low while in MEM waiting on a store → mem_req and mem_we fall to 0 without waiting for a clock edge. After release the FSM restarts from IDLE.
